// File: rtl/product_accumulator.sv
// Accumulates multiplier products into frame sums and hands each frame out over a valid/ready handshake.
// Optional build macro SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
`timescale 1ns/1ps
module product_accumulator #(
    parameter int PROD_W    = 4,
    parameter int ACC_W     = 12,
    parameter int FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [7:0]        out_count,
    output logic              out_ovf
);

    typedef enum logic {ACCUM, DONE} state_t;

    localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [7:0]       cnt, cnt_next;
    logic             ovf, ovf_next;
    logic [ACC_W:0]   sum_ext;
    logic             accept, out_take, frame_end;

    assign accept   = in_valid && in_ready;
    assign out_take = out_valid && out_ready;

    // One extra bit on the add exposes the carry that marks overflow.
    always_comb begin
        sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
        acc_next = acc;
        cnt_next = cnt;
        ovf_next = ovf;
        if (accept) begin
`ifdef SATURATE_EN
            acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
            acc_next = sum_ext[ACC_W-1:0];
`endif
            cnt_next = cnt + 8'd1;
            ovf_next = ovf | sum_ext[ACC_W];
        end
    end

    // A flush only closes a frame that holds at least one product.
    always_comb begin
        frame_end = (state == ACCUM) &&
                    ((accept && cnt == LAST) || (flush && (cnt != 8'd0 || accept)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (frame_end) state_next = DONE;
            DONE:    if (out_take)  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (out_take) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (frame_end) begin
                out_sum   <= acc_next;
                out_count <= cnt_next;
                out_ovf   <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a frame-level reference model queues expected results,
// and an independent monitor compares them whenever the DUT presents a frame.
`timescale 1ns/1ps
module tb_product_accumulator;

    localparam int PROD_W    = 4;
    localparam int ACC_W     = 5;
    localparam int FRAME_LEN = 4;
    localparam int MAX_SUM   = (1 << ACC_W) - 1;

    typedef struct {
        int sum;
        int count;
        int ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_sum;
    logic [7:0]        out_count;
    logic              out_ovf;

    int   errors = 0;
    int   checks = 0;
    int   frame_q[$];
    exp_t exp_q[$];
    bit   m_done = 1'b0;

    product_accumulator #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // The frame result is derived from the plain arithmetic total of its products.
    task automatic pushExpected();
        exp_t e;
        int   total = 0;
        foreach (frame_q[i]) total += frame_q[i];
        e.count = frame_q.size();
        e.ovf   = (total > MAX_SUM) ? 1 : 0;
`ifdef SATURATE_EN
        e.sum = (total > MAX_SUM) ? MAX_SUM : total;
`else
        e.sum = total % (MAX_SUM + 1);
`endif
        exp_q.push_back(e);
        frame_q.delete();
    endtask

    // Called at a falling edge; drives one cycle, predicts its effect, returns at the next falling edge.
    task automatic applyStimulus(input bit v, input int p, input bit f, input bit r, output bit accepted);
        in_valid  = v;
        in_prod   = PROD_W'(p);
        flush     = f;
        out_ready = r;
        #1;
        checkOutput("in_ready", int'(in_ready), int'(!m_done));
        checkOutput("out_valid", int'(out_valid), int'(m_done));
        accepted = 1'b0;
        if (m_done) begin
            if (r) m_done = 1'b0;
        end else begin
            if (v) begin
                frame_q.push_back(p);
                accepted = 1'b1;
            end
            if ((v && frame_q.size() == FRAME_LEN) || (f && frame_q.size() > 0)) begin
                pushExpected();
                m_done = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic sendProd(input int p, input bit f);
        bit a = 1'b0;
        int tries = 0;
        while (!a && tries < 20) begin
            applyStimulus(1'b1, p, f, 1'b1, a);
            tries++;
        end
        checkOutput("send_accepted", int'(a), 1);
    endtask

    task automatic idle(input int n, input bit r);
        bit a;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, r, a);
    endtask

    // Reset is raised between clock edges to exercise the asynchronous path.
    task automatic resetDut();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_sum", int'(out_sum), 0);
        checkOutput("rst_out_count", int'(out_count), 0);
        checkOutput("rst_out_ovf", int'(out_ovf), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        frame_q.delete();
        exp_q.delete();
        m_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame: got sum=%0d count=%0d expected no frame",
                             out_sum, out_count);
                end else begin
                    checkOutput("out_sum", int'(out_sum), exp_q[0].sum);
                    checkOutput("out_count", int'(out_count), exp_q[0].count);
                    checkOutput("out_ovf", int'(out_ovf), exp_q[0].ovf);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : driver
        bit a;
        int pending;
        resetDut();
        idle(3, 1'b1);

        $display("[TB] full frame");
        sendProd(3, 0); sendProd(6, 0); sendProd(4, 0); sendProd(9, 0);
        idle(2, 1'b1);

        $display("[TB] backpressure");
        sendProd(3, 0); sendProd(6, 0); sendProd(4, 0); sendProd(9, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5, 1'b0, 1'b0, a);
        applyStimulus(1'b1, 5, 1'b0, 1'b1, a);
        sendProd(5, 0); sendProd(1, 0); sendProd(2, 0); sendProd(3, 0);
        idle(2, 1'b1);

        $display("[TB] early flush");
        sendProd(9, 0); sendProd(3, 0); sendProd(4, 1);
        idle(2, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b1, a);
        idle(3, 1'b1);

        $display("[TB] overflow");
        sendProd(9, 0); sendProd(9, 0); sendProd(9, 0); sendProd(9, 0);
        idle(2, 1'b1);

        $display("[TB] reset mid-frame");
        sendProd(4, 0); sendProd(5, 0);
        resetDut();
        sendProd(3, 0); sendProd(6, 0); sendProd(4, 0); sendProd(9, 0);
        idle(2, 1'b1);

        $display("[TB] random traffic");
        pending = int'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, pending, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0, a);
            if (a) pending = int'($urandom_range(0, 15));
        end
        idle(4, 1'b1);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream stage of the 2x2 combinational multiplier. Consumes its 4-bit products over a valid/ready handshake and accumulates them into a frame sum. After FRAME_LEN products, or on an early flush, it presents the sum, sample count and overflow flag on a held-until-taken output handshake. This turns the multiplier into a dot-product / MAC datapath for the homework designs.

Parameters:
PROD_W, 4, width of the incoming product (the multiplier's m output).
ACC_W, 12, accumulator and out_sum width; must be >= PROD_W.
FRAME_LEN, 8, products per frame; range 1..255.

Ports:
clk  input  1  single clock; all state changes on posedge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_prod is valid this cycle.
in_ready  output  1  block can accept a product this cycle.
in_prod  input  PROD_W  unsigned product from the multiplier.
flush  input  1  end the current frame early (single-cycle pulse).
out_valid  output  1  frame result available.
out_ready  input  1  consumer takes the result this cycle.
out_sum  output  ACC_W  unsigned frame sum.
out_count  output  8  number of products in the frame.
out_ovf  output  1  sum exceeded 2^ACC_W-1 during the frame.

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, any time, including mid-frame or while out_valid is high):
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 (once rst deasserts).
  - The partial frame is discarded.
- Accept: in_valid && in_ready at a posedge. Output handshake: out_valid && out_ready at a posedge.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc + in_prod (ACC_W+1-bit add), cnt <= cnt+1, ovf set if carry out.
  - Frame end occurs on an accept with cnt==FRAME_LEN-1, or on flush with (cnt>0 or accept this cycle).
  - At frame end: out_sum/out_count/out_ovf are registered from the final values (including this cycle's product), and the state moves to DONE.
- State DONE:
  - in_ready=0, out_valid=1.
  - out_sum/out_count/out_ovf stay stable until the output handshake.
  - On the output handshake: acc=0, cnt=0, ovf=0, state moves to ACCUM; in_ready is 1 the next cycle.
- Latency: out_valid rises on the cycle after the accept (or flush) that ends the frame. Throughput is FRAME_LEN products per FRAME_LEN+1 cycles when out_ready is held high.
- Boundary conditions:
  - flush with cnt==0 and no accept: ignored, no empty frame is emitted.
  - flush and accept in the same cycle: the product is included, then the frame ends.
  - flush while in DONE: ignored.
  - in_valid while in DONE: not accepted (in_ready=0); the producer holds its data.
  - FRAME_LEN=1: every accept ends a frame.
  - out_ready asserted while out_valid=0: no effect.
- Overflow: ovf is sticky within a frame. Accumulation behaviour on overflow is set by SATURATE_EN.
- in_prod is unsigned; there is no sign extension.

Optional Feature:
SATURATE_EN
- Defined: on carry out, acc clamps to 2^ACC_W-1 and stays there for the rest of the frame; ovf=1.
- Undefined: acc wraps modulo 2^ACC_W; ovf is still set on the first carry out.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/idle: assert rst mid-cycle asynchronously -> out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 immediately; no frame after release with in_valid=0.
- Full frame (FRAME_LEN=4, out_ready=1): feed 0011, 0110, 0100, 1001 (products of 01*11, 11*10, 10*10, 11*11) -> next cycle out_valid=1, out_sum=22, out_count=4, out_ovf=0; in_ready=1 one cycle later.
- Backpressure (FRAME_LEN=4): same frame with out_ready=0 for 5 cycles -> out_sum=22 held stable, in_ready=0 throughout, in_valid products not consumed; after out_ready=1 for 1 cycle, the next frame starts from acc=0.
- Early flush: FRAME_LEN=8; feed 1001, 0011; pulse flush together with the third product 0100 -> out_sum=16, out_count=3; a flush pulse at cnt==0 -> no out_valid.
- Overflow (ACC_W=5, FRAME_LEN=4, four x 1001): SATURATE_EN defined -> out_sum=31, out_ovf=1; undefined -> out_sum=4 (36 mod 32), out_ovf=1.
- Reset mid-frame: after 2 accepts (sum 9), pulse rst, then feed 0011, 0110, 0100, 1001 (FRAME_LEN=4) -> out_sum=22, out_count=4 (no carry-over from before reset).
